// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
//   state_t      : sequencer states (idle, iterate, result fix-up, completion pulse)
//   OP_MULT/DIV  : encoding of the op input
//   XLEN, STEPS  : operand width and iteration count; CNT_W sizes the step counter
//   mag()        : two's-complement magnitude (0x80000000 maps to itself, read unsigned)
package multdiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned STEPS = 32;
    localparam int unsigned CNT_W = $clog2(STEPS);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? ((~v) + 1) : v;
    endfunction

endpackage

// File: rtl/mult_div_ctrl_div_step.sv
// div_step: one combinational restoring-division step on a packed {remainder, quotient}
// pair. Compiled only when MULTDIV_DIV_EN is defined.
//   rem_quot      in  64  current {remainder, dividend/quotient bits}
//   divisor       in  32  divisor magnitude
//   rem_quot_next out 64  pair after shift, trial subtract and restore
`ifdef MULTDIV_DIV_EN
module div_step
    import multdiv_pkg::*;
(
    input  logic [2*XLEN-1:0] rem_quot,
    input  logic [XLEN-1:0]   divisor,
    output logic [2*XLEN-1:0] rem_quot_next
);

    logic [2*XLEN-1:0] shifted;
    logic [XLEN:0]     trial;
    // Remainder is always below the divisor, so its MSB is zero before the shift.
    logic              unused_rem_msb;

    assign unused_rem_msb = rem_quot[2*XLEN-1];

    always_comb begin
        shifted = {rem_quot[2*XLEN-2:0], 1'b0};
        trial   = {1'b0, shifted[2*XLEN-1:XLEN]} - {1'b0, divisor};
        if (trial[XLEN]) begin
            // Borrow: keep the shifted remainder, quotient bit stays 0.
            rem_quot_next = shifted;
        end else begin
            rem_quot_next = {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative signed MULT/DIV sequencer owning the HI and LO registers.
// MULT: 32 radix-2 Booth steps. DIV: 32 restoring steps on magnitudes, then sign fix.
// Optional feature macro: MULTDIV_DIV_EN (undefined: any DIV completes like divide-by-zero).
//   clk       in   1  rising-edge clock
//   reset_n   in   1  asynchronous active-low reset
//   start     in   1  request strobe, sampled only in idle
//   op        in   1  0 = MULT, 1 = DIV
//   a, b      in  32  signed operands, captured at the accept edge
//   busy      out  1  high while iterating and during fix-up
//   done      out  1  one-cycle completion pulse
//   div_zero  out  1  high with done when the accepted DIV was rejected
//   hi_out    out 32  HI register
//   lo_out    out 32  LO register
module mult_div_ctrl
    import multdiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_q;
    logic [XLEN-1:0]   a_q;
    // MULT: {acc, multiplier, q-1}. DIV: {1'b0, remainder, quotient}.
    logic [2*XLEN:0]   work;

    logic [2*XLEN:0]   init_work;
    logic [2*XLEN:0]   step_work;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic              div_reject;

    logic [XLEN:0]     booth_acc;
    logic [XLEN:0]     booth_m;
    logic [XLEN:0]     booth_sum;
    logic [2*XLEN:0]   booth_next;

    // Booth step. The add is done one bit wider so the shift sees the true sign even
    // when the multiplicand is the most negative value.
    always_comb begin
        booth_acc = {work[2*XLEN], work[2*XLEN:XLEN+1]};
        booth_m   = {a_q[XLEN-1], a_q};
        unique case (work[1:0])
            2'b01:   booth_sum = booth_acc + booth_m;
            2'b10:   booth_sum = booth_acc - booth_m;
            default: booth_sum = booth_acc;
        endcase
        booth_next = {booth_sum, work[XLEN:1]};
    end

`ifdef MULTDIV_DIV_EN
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    assign b_mag = mag(b_q);

    div_step u_div_step (
        .rem_quot      (work[2*XLEN-1:0]),
        .divisor       (b_mag),
        .rem_quot_next (div_next)
    );

    assign quo = work[XLEN-1:0];
    assign rem = work[2*XLEN-1:XLEN];

    always_comb begin
        div_reject = (b == '0);
        if (op == OP_DIV) begin
            init_work = {1'b0, {XLEN{1'b0}}, mag(a)};
        end else begin
            init_work = {{XLEN{1'b0}}, b, 1'b0};
        end
        if (op_q == OP_DIV) begin
            step_work = {1'b0, div_next};
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            res_lo    = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? ((~quo) + 1) : quo;
            res_hi    = a_q[XLEN-1] ? ((~rem) + 1) : rem;
        end else begin
            step_work = booth_next;
            res_hi    = work[2*XLEN:XLEN+1];
            res_lo    = work[XLEN:1];
        end
    end
`else
    always_comb begin
        div_reject = 1'b1;
        init_work  = {{XLEN{1'b0}}, b, 1'b0};
        step_work  = (op_q == OP_MULT) ? booth_next : work;
        res_hi     = work[2*XLEN:XLEN+1];
        res_lo     = work[XLEN:1];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            cnt      <= '0;
            op_q     <= OP_MULT;
            a_q      <= '0;
            work     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
`ifdef MULTDIV_DIV_EN
            b_q      <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        a_q  <= a;
                        op_q <= op;
                        cnt  <= '0;
`ifdef MULTDIV_DIV_EN
                        b_q  <= b;
`endif
                        if (op == OP_DIV && div_reject) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= StRun;
                            busy  <= 1'b1;
                            work  <= init_work;
                        end
                    end
                end
                StRun: begin
                    work <= step_work;
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state <= StFix;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StFix: begin
                    hi_out <= res_hi;
                    lo_out <= res_lo;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= StDone;
                end
                StDone: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl; expectations come from a behavioural model
// pushed to a scoreboard at issue time and popped when done is seen.
// Honours MULTDIV_DIV_EN the same way as the design.
module tb_mult_div_ctrl;

`ifdef MULTDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    always #5 clk = ~clk;

    mult_div_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          total = 0;
    int          bad = 0;

    task automatic push_expect(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint p;
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 1'b0;
        if (o == 1'b0) begin
            p    = sx * sy;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (y == 32'd0 || !DivEn) begin
            e.dz = 1'b1;
        end else begin
            p    = sx / sy;
            m_lo = p[31:0];
            p    = sx % sy;
            m_hi = p[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
    endtask

    // Issues one request, then checks latency, busy length and the committed result.
    task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input string name);
        exp_t e;
        int   cyc;
        int   bcnt;
        int   lat;
        bit   seen;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        push_expect(o, x, y);
        @(posedge clk); #1;
        // Operand changes after the accept edge must not matter.
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        cyc = 0; bcnt = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) bcnt++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        e = sb.pop_front();
        lat = e.dz ? 0 : 33;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: done never seen within %0d cycles", name, cyc);
        end
        total++;
        if (cyc !== lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        total++;
        if (bcnt !== lat) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, lat);
        end
        total++;
        if (hi_out !== e.hi || lo_out !== e.lo) begin
            bad++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h",
                     name, hi_out, lo_out, e.hi, e.lo);
        end
        total++;
        if (div_zero !== e.dz || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s flags: got div_zero=%b busy=%b want div_zero=%b busy=0",
                     name, div_zero, busy, e.dz);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse_width: got done=%b div_zero=%b want 0 0",
                     name, done, div_zero);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        total++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi_out, lo_out);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'd0) begin
            bad++;
            $display("FAIL reset_release: got busy=%b done=%b hi=%h lo=%h want all 0",
                     busy, done, hi_out, lo_out);
        end
    endtask

    task automatic test_mult();
        do_op(1'b0, 32'd3, 32'hFFFF_FFFB, "mult_3_m5");
        total++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF1) begin
            bad++;
            $display("FAIL mult_3_m5_const: got hi=%h lo=%h want FFFFFFFF FFFFFFF1",
                     hi_out, lo_out);
        end
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
        total++;
        if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin
            bad++;
            $display("FAIL mult_min_min_const: got hi=%h lo=%h want 40000000 00000000",
                     hi_out, lo_out);
        end
        do_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, "mult_max_min");
        do_op(1'b0, 32'h0, 32'h1234_5678, "mult_zero");
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, $urandom, $urandom, "mult_rand");
        end
    endtask

    task automatic test_div();
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
        do_op(1'b1, 32'd3, 32'd10, "div_small");
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, $urandom, $urandom | 32'd1, "div_rand");
        end
        if (DivEn) begin
            total++;
            if (lo_out !== m_lo) begin
                bad++;
                $display("FAIL div_model_sync: got lo=%h want %h", lo_out, m_lo);
            end
        end
    endtask

    task automatic test_div_zero();
        do_op(1'b0, 32'h3333_3333, 32'h5555_5556, "preload");
        total++;
        if (hi_out !== 32'h1111_1111 || lo_out !== 32'h2222_2222) begin
            bad++;
            $display("FAIL preload_const: got hi=%h lo=%h want 11111111 22222222",
                     hi_out, lo_out);
        end
        do_op(1'b1, 32'd5, 32'd0, "div_by_zero");
        total++;
        if (hi_out !== 32'h1111_1111 || lo_out !== 32'h2222_2222) begin
            bad++;
            $display("FAIL div_by_zero_keep: got hi=%h lo=%h want 11111111 22222222",
                     hi_out, lo_out);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
        push_expect(1'b0, 32'd6, 32'd7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 5; seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        e = sb.pop_front();
        total++;
        if (!seen || cyc !== 33) begin
            bad++;
            $display("FAIL ignore_start_latency: got seen=%b cyc=%0d want 1 33", seen, cyc);
        end
        total++;
        if (hi_out !== e.hi || lo_out !== e.lo || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_result: got hi=%h lo=%h dz=%b want %h %h 0",
                     hi_out, lo_out, div_zero, e.hi, e.lo);
        end
        total++;
        if (lo_out !== 32'd42 || hi_out !== 32'd0) begin
            bad++;
            $display("FAIL ignore_start_const: got hi=%h lo=%h want 0 42", hi_out, lo_out);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_no_queue: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd123; b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi_out, lo_out);
        end
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        do_op(1'b0, 32'd2, 32'd2, "mult_after_reset");
        total++;
        if (lo_out !== 32'd4 || hi_out !== 32'd0) begin
            bad++;
            $display("FAIL mult_after_reset_const: got hi=%h lo=%h want 0 4", hi_out, lo_out);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Iterative signed multiply/divide sequencer that owns the HI and LO registers of the multicycle MIPS datapath. It accepts one MULT or DIV request at a time from the main control unit and runs a 32-step shift-add or restoring-division sequence. It holds `busy` while working and writes HI/LO once at the end. Its `hi_out`/`lo_out` drive the HI and LO inputs of the write-back data-source mux (selects 3'b001/3'b010), so MFHI/MFLO read whatever this block last committed.

## Interface
- No parameters; the width is fixed at 32 (see package constants).
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request strobe; sampled only in IDLE
- `op`  in  1  0 = MULT, 1 = DIV
- `a`  in  32  multiplicand / dividend (signed); captured at accept edge
- `b`  in  32  multiplier / divisor (signed); captured at accept edge
- `busy`  out  1  high in RUN and FIX
- `done`  out  1  one-cycle pulse, high in DONE
- `div_zero`  out  1  high in DONE only when the accepted DIV had `b == 0`
- `hi_out`  out  32  HI register
- `lo_out`  out  32  LO register

## Operation
- States: IDLE, RUN, FIX, DONE. Encoding comes from the package.
- **Reset values:** state IDLE; `busy`, `done` and `div_zero` are 0; `hi_out` and `lo_out` are 0x00000000; internal counter and work registers are 0.
- **IDLE:**
  - `start=1` latches `a`, `b`, `op` and zeroes the step counter.
  - For a DIV with `b==0`, the next state is DONE with `div_zero=1`. Otherwise the next state is RUN.
  - `start=0` stays in IDLE.
- **RUN:** one step per cycle, 32 steps. The counter runs 0..31, and the step with counter 31 moves to FIX.
  - MULT uses radix-2 Booth on a 65-bit {acc, multiplier, q-1} with arithmetic right shift.
  - DIV uses restoring division on magnitudes |a| and |b|: 64-bit remainder/quotient shift, subtract, restore on negative.
- **FIX:** computes the final result and writes HI/LO, then goes to DONE.
  - MULT: HI:LO = the signed 64-bit product.
  - DIV: LO = quotient truncated toward zero (negated if the signs of `a` and `b` differ). HI = remainder with the sign of `a`.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps; no flag).
- **DONE:** `done=1` for exactly one cycle, then IDLE. `div_zero` clears with `done`.
- **Divide by zero:** HI/LO are left unchanged.
- `start` outside IDLE is ignored. No queuing.
- Input changes after the accept edge have no effect.
- HI/LO change only on the FIX→DONE edge or on reset.

## Timing
Let edge t be the rising edge that accepts `start`.
- **Normal operation:**
  - RUN occupies edges t+1..t+32.
  - Edge t+33 writes HI/LO and enters DONE.
  - `busy` is high from after edge t until edge t+33.
  - `done` is high from after edge t+33 until edge t+34, with the new HI/LO already visible.
- **Divide by zero:** `done` and `div_zero` are high from after edge t until edge t+1. `busy` never asserts.
- **Back-to-back:** the earliest next accept is edge t+34 (t+1 after a divide-by-zero).
- **Reset mid-operation:** asserting `reset_n` low at any time forces IDLE and zeroes all outputs immediately (asynchronously). The partial result is discarded.

## Configuration
- **`MULTDIV_DIV_EN` defined:** full DIV path as described above.
- **`MULTDIV_DIV_EN` undefined:**
  - The restoring-division datapath and the DIV sign fix are not compiled.
  - A request with `op=1` completes like a divide-by-zero: `done` and `div_zero` pulse one cycle after accept, and HI/LO are unchanged.
  - MULT behaviour and timing are identical in both builds.

## Structure
- Package `multdiv_pkg` holds:
  - the state enum typedef (IDLE, RUN, FIX, DONE);
  - op encodings `OP_MULT=1'b0` and `OP_DIV=1'b1`;
  - `XLEN=32`, and `STEPS=32` with the counter width derived from it.
- One sub-module, `div_step`: a combinational single restoring-division step (shift remainder/quotient, trial subtract, restore). It is instantiated once and compiled only under `MULTDIV_DIV_EN`.

## Test plan
- MULT a=3, b=0xFFFFFFFB (−5) → at t+33: `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` high for exactly 33 cycles.
- MULT a=0x80000000, b=0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV a=5, b=0 with HI/LO preloaded to 0x11111111 and 0x22222222 → `done`=`div_zero`=1 in cycle t+1, `busy` stays 0, HI/LO unchanged.
- `start` pulsed at t+5 with different operands during a MULT 6×7 → ignored, result HI=0, LO=42.
- `reset_n` low at t+10 of a MULT → `busy`=0, HI=LO=0 immediately. After release, a new MULT 2×2 gives LO=4 at accept+33.
